// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_driver
// Description : Multiplexed common-anode 7-segment driver. Latches packed
//               4-bit digit values and decimal points on a load strobe,
//               decodes them to hex glyphs with optional leading-zero
//               blanking, and scans them onto the digits at a rate set by
//               an internal prescaler.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_driver #(
    parameter int REFRESH_DIV = 100000,
    parameter int DIGITS      = 4,
    parameter int BLANK_LZ    = 1,
    localparam int c_idx_w    = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   digits_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  load,
    input  logic                  enable,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [c_idx_w-1:0]    digit_idx,
    output logic                  scan_tick
);

    localparam int                   c_presc_w    = $clog2(REFRESH_DIV);
    localparam logic [c_presc_w-1:0] c_presc_last = c_presc_w'(REFRESH_DIV - 1);
    localparam logic [c_idx_w-1:0]   c_idx_last   = c_idx_w'(DIGITS - 1);

    logic [c_presc_w-1:0] r_presc;
    logic [c_idx_w-1:0]   r_idx;
    logic                 r_tick;
    logic [4*DIGITS-1:0]  r_digits;
    logic [DIGITS-1:0]    r_dp;
    logic [DIGITS-1:0]    r_an;
    logic [6:0]           r_seg;
    logic                 r_dp_out;

    logic [3:0]           w_nib;
    logic [6:0]           w_glyph;
    logic [DIGITS-1:0]    w_lz;
    logic                 w_run;
    logic [DIGITS-1:0]    w_an_sel;

    // Prescaler and digit index: idx advances (with a tick) when presc wraps
    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc <= '0;
            r_idx   <= '0;
            r_tick  <= 1'b0;
        end else if (r_presc == c_presc_last) begin
            r_presc <= '0;
            r_idx   <= (r_idx == c_idx_last) ? '0 : r_idx + 1'b1;
            r_tick  <= 1'b1;
        end else begin
            r_presc <= r_presc + 1'b1;
            r_tick  <= 1'b0;
        end
    end

    // Level-sampled capture of the digit values and decimal points
    always_ff @(posedge clk) begin
        if (rst) begin
            r_digits <= '0;
            r_dp     <= '0;
        end else if (load) begin
            r_digits <= digits_in;
            r_dp     <= dp_in;
        end
    end

    // Leading-zero map: bit i set when digit i and every higher digit are 0;
    // digit 0 is always shown so a zero value still reads "0"
    always_comb begin
        w_lz  = '0;
        w_run = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            w_run   = w_run & (r_digits[4*i +: 4] == 4'h0);
            w_lz[i] = w_run;
        end
        w_lz[0] = 1'b0;
    end

    assign w_nib    = r_digits[{r_idx, 2'b00} +: 4];
    assign w_an_sel = DIGITS'(1) << r_idx;

    // Hex glyph decode, active-low {g,f,e,d,c,b,a}
    always_comb begin
        w_glyph = 7'h7F;
        case (w_nib)
            4'h0: w_glyph = 7'h40;
            4'h1: w_glyph = 7'h79;
            4'h2: w_glyph = 7'h24;
            4'h3: w_glyph = 7'h30;
            4'h4: w_glyph = 7'h19;
            4'h5: w_glyph = 7'h12;
            4'h6: w_glyph = 7'h02;
            4'h7: w_glyph = 7'h78;
            4'h8: w_glyph = 7'h00;
            4'h9: w_glyph = 7'h10;
            4'hA: w_glyph = 7'h08;
            4'hB: w_glyph = 7'h03;
            4'hC: w_glyph = 7'h46;
            4'hD: w_glyph = 7'h21;
            4'hE: w_glyph = 7'h06;
            4'hF: w_glyph = 7'h0E;
            default: w_glyph = 7'h7F;
        endcase
    end

    // Registered pin drivers; seg/dp keep updating while anodes are disabled
    always_ff @(posedge clk) begin
        if (rst) begin
            r_an     <= '1;
            r_seg    <= 7'h7F;
            r_dp_out <= 1'b1;
        end else begin
            r_an     <= enable ? ~w_an_sel : '1;
            r_seg    <= ((BLANK_LZ != 0) && w_lz[r_idx]) ? 7'h7F : w_glyph;
            r_dp_out <= ~r_dp[r_idx];
        end
    end

    assign an        = r_an;
    assign seg       = r_seg;
    assign dp        = r_dp_out;
    assign digit_idx = r_idx;
    assign scan_tick = r_tick;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_scan_driver
// Description : Self-checking bench for seg7_scan_driver (REFRESH_DIV=4,
//               DIGITS=4, BLANK_LZ=1) against a cycle-count reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_driver;

    localparam int DIV = 4;
    localparam int ND  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] digits_in = '0;
    logic [3:0]  dp_in = '0;
    logic        load = 1'b0;
    logic        enable = 1'b1;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [1:0]  digit_idx;
    logic        scan_tick;

    seg7_scan_driver #(.REFRESH_DIV(DIV), .DIGITS(ND), .BLANK_LZ(1)) dut (
        .clk(clk), .rst(rst), .digits_in(digits_in), .dp_in(dp_in),
        .load(load), .enable(enable), .an(an), .seg(seg), .dp(dp),
        .digit_idx(digit_idx), .scan_tick(scan_tick)
    );

    always #5 clk = ~clk;

    logic [6:0] GLYPH [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: cycles since reset release, latched data, expected pins
    int          m_cnt = 0;
    logic [15:0] m_digits = '0;
    logic [3:0]  m_dpv = '0;
    logic [3:0]  exp_an;
    logic [6:0]  exp_seg;
    logic        exp_dp;
    logic [1:0]  exp_idx;
    logic        exp_tick;

    // Advance one clock and update the model from the inputs seen at the edge
    task automatic cyc();
        logic        s_rst, s_load, s_en;
        logic [15:0] s_din, upper;
        logic [3:0]  s_dpin, nib;
        int          oi;
        s_rst = rst; s_load = load; s_en = enable; s_din = digits_in; s_dpin = dp_in;
        @(posedge clk);
        if (s_rst) begin
            m_cnt = 0; m_digits = '0; m_dpv = '0;
            exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1; exp_idx = 2'd0; exp_tick = 1'b0;
        end else begin
            oi     = (m_cnt / DIV) % ND;
            exp_an = s_en ? ~(4'b0001 << oi) : 4'hF;
            upper  = m_digits >> (4 * oi);
            nib    = upper[3:0];
            exp_seg = (upper == 16'h0 && oi != 0) ? 7'h7F : GLYPH[nib];
            exp_dp = ~m_dpv[oi];
            m_cnt++;
            if (s_load) begin
                m_digits = s_din;
                m_dpv    = s_dpin;
            end
            exp_idx  = 2'((m_cnt / DIV) % ND);
            exp_tick = (m_cnt % DIV) == 0;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; load = 1'b1; enable = 1'b1;
        digits_in = 16'h9ABC; dp_in = 4'hF;
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_tests++;
            if ({an, seg, dp, digit_idx, scan_tick} !== {4'hF, 7'h7F, 1'b1, 2'd0, 1'b0}) begin
                n_fail++;
                $display("FAIL reset_state: an=%h seg=%h dp=%b idx=%0d tick=%b, expected an=F seg=7F dp=1 idx=0 tick=0",
                         an, seg, dp, digit_idx, scan_tick);
            end
        end
        rst = 1'b0; load = 1'b0;
        cyc();
        n_tests++;
        if (an !== 4'hE || seg !== 7'h40) begin
            n_fail++;
            $display("FAIL reset_release: an=%h seg=%h, expected an=E seg=40", an, seg);
        end
    endtask

    task automatic test_scan();
        for (int i = 0; i < 40; i++) begin
            cyc();
            n_tests++;
            if ({an, seg, dp, digit_idx, scan_tick} !== {exp_an, exp_seg, exp_dp, exp_idx, exp_tick}) begin
                n_fail++;
                $display("FAIL scan c%0d: an=%h idx=%0d tick=%b seg=%h, expected an=%h idx=%0d tick=%b seg=%h",
                         i, an, digit_idx, scan_tick, seg, exp_an, exp_idx, exp_tick, exp_seg);
            end
        end
    endtask

    task automatic test_decode();
        for (int v = 0; v < 8; v++) begin
            if (v == 0) begin
                digits_in = 16'h1234; dp_in = 4'b0100;
            end else begin
                digits_in = 16'($urandom); dp_in = 4'($urandom);
            end
            load = 1'b1;
            cyc();
            load = 1'b0;
            for (int i = 0; i < ND * DIV + 2; i++) begin
                cyc();
                n_tests++;
                if ({an, seg, dp, digit_idx} !== {exp_an, exp_seg, exp_dp, exp_idx}) begin
                    n_fail++;
                    $display("FAIL decode v%0d c%0d: an=%h seg=%h dp=%b, expected an=%h seg=%h dp=%b",
                             v, i, an, seg, dp, exp_an, exp_seg, exp_dp);
                end
            end
        end
    endtask

    task automatic test_blank();
        logic [15:0] pat [4];
        pat[0] = 16'h0050; pat[1] = 16'h0000; pat[2] = 16'h0700; pat[3] = 16'h000A;
        for (int v = 0; v < 8; v++) begin
            if (v < 4) digits_in = pat[v];
            else       digits_in = 16'($urandom) & (16'hFFFF >> (4 * $urandom_range(1, 3)));
            dp_in = 4'($urandom);
            load = 1'b1;
            cyc();
            load = 1'b0;
            for (int i = 0; i < ND * DIV + 2; i++) begin
                cyc();
                n_tests++;
                if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
                    n_fail++;
                    $display("FAIL blank v%0d c%0d: an=%h seg=%h dp=%b, expected an=%h seg=%h dp=%b",
                             v, i, an, seg, dp, exp_an, exp_seg, exp_dp);
                end
            end
        end
    endtask

    task automatic test_enable();
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 4) == 0) enable = ~enable;
            cyc();
            n_tests++;
            if ({an, seg, dp, digit_idx, scan_tick} !== {exp_an, exp_seg, exp_dp, exp_idx, exp_tick}) begin
                n_fail++;
                $display("FAIL enable c%0d: an=%h idx=%0d tick=%b, expected an=%h idx=%0d tick=%b",
                         i, an, digit_idx, scan_tick, exp_an, exp_idx, exp_tick);
            end
        end
        enable = 1'b1;
    endtask

    task automatic test_load_tick();
        for (int r = 0; r < 4; r++) begin
            int guard = 0;
            while (!exp_tick && guard < 2 * DIV) begin
                cyc();
                guard++;
            end
            n_tests++;
            if (!exp_tick || scan_tick !== 1'b1) begin
                n_fail++;
                $display("FAIL load_tick_sync r%0d: tick=%b, expected 1 within %0d cycles", r, scan_tick, 2 * DIV);
            end
            digits_in = 16'($urandom); dp_in = 4'($urandom); load = 1'b1;
            for (int i = 0; i < 3; i++) begin
                cyc();
                load = 1'b0;
                n_tests++;
                if ({an, seg, dp, digit_idx} !== {exp_an, exp_seg, exp_dp, exp_idx}) begin
                    n_fail++;
                    $display("FAIL load_tick r%0d c%0d: an=%h seg=%h dp=%b, expected an=%h seg=%h dp=%b",
                             r, i, an, seg, dp, exp_an, exp_seg, exp_dp);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        digits_in = 16'h8F3E; dp_in = 4'hF; load = 1'b1;
        cyc();
        load = 1'b0;
        repeat (6) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        n_tests++;
        if ({an, seg, dp, digit_idx, scan_tick} !== {4'hF, 7'h7F, 1'b1, 2'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_mid: an=%h seg=%h dp=%b idx=%0d tick=%b, expected an=F seg=7F dp=1 idx=0 tick=0",
                     an, seg, dp, digit_idx, scan_tick);
        end
        for (int i = 0; i < ND * DIV + 1; i++) begin
            cyc();
            n_tests++;
            if ({an, seg, dp, digit_idx, scan_tick} !== {exp_an, exp_seg, exp_dp, exp_idx, exp_tick}) begin
                n_fail++;
                $display("FAIL reset_cleared c%0d: an=%h seg=%h dp=%b, expected an=%h seg=%h dp=%b",
                         i, an, seg, dp, exp_an, exp_seg, exp_dp);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst       = ($urandom_range(0, 99) == 0);
            load      = ($urandom_range(0, 3) == 0);
            enable    = ($urandom_range(0, 5) != 0);
            digits_in = 16'($urandom);
            dp_in     = 4'($urandom);
            cyc();
            n_tests++;
            if ({an, seg, dp, digit_idx, scan_tick} !== {exp_an, exp_seg, exp_dp, exp_idx, exp_tick}) begin
                n_fail++;
                $display("FAIL random c%0d: an=%h seg=%h dp=%b idx=%0d tick=%b, expected an=%h seg=%h dp=%b idx=%0d tick=%b",
                         i, an, seg, dp, digit_idx, scan_tick, exp_an, exp_seg, exp_dp, exp_idx, exp_tick);
            end
        end
        rst = 1'b0; load = 1'b0; enable = 1'b1;
    endtask

    initial begin
        test_reset();
        test_scan();
        test_decode();
        test_blank();
        test_enable();
        test_load_tick();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
